// File: rtl/spike_pattern_decoder.sv
// Counts spikes per neuron over a fixed window and thresholds the counts into a pattern word.
// Optional STABILITY_CHECK_EN: flags convergence after STABLE_WINDOWS identical patterns.
module spike_pattern_decoder #(
    parameter int N              = 7,
    parameter int WINDOW         = 256,
    parameter int CNT_W          = 8,
    parameter int THRESH         = 4,
    parameter int STABLE_WINDOWS = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [N-1:0] spikes,
    input  logic         out_ready,
    output logic [N-1:0] pattern_out,
    output logic         out_valid,
    output logic         overrun,
    output logic         converged,
    output logic [1:0]   state_dbg
);

    // Output handshake: a result transfers on any cycle where out_valid & out_ready.
    // pattern_out holds steady while out_valid is high and not yet accepted.
    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, EVAL = 2'd2} state_t;

    localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0]    LAST    = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    state_t            state;
    logic [TW-1:0]     timer;
    logic [CNT_W-1:0]  cnt [N];
    logic [N-1:0]      pat;

    always_comb begin
        pat = '0;
        for (int i = 0; i < N; i++) pat[i] = (cnt[i] >= THR);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            timer       <= '0;
            pattern_out <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            // Acceptance clears out_valid; a same-cycle EVAL load below overrides it.
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= COUNT;
                        timer <= '0;
                        for (int i = 0; i < N; i++) cnt[i] <= '0;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state <= IDLE;
                        timer <= '0;
                        for (int i = 0; i < N; i++) cnt[i] <= '0;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (spikes[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                        if (timer == LAST) begin
                            state <= EVAL;
                            timer <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                EVAL: begin
                    if (!out_valid || out_ready) begin
                        pattern_out <= pat;
                        out_valid   <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    timer <= '0;
                    for (int i = 0; i < N; i++) cnt[i] <= '0;
                    state <= enable ? COUNT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STABILITY_CHECK_EN
    localparam int SW = $clog2(STABLE_WINDOWS) + 1;

    logic [N-1:0]  prev_pat;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_next;
    logic          converged_r;

    // Dropped (overrun) results still take part in the stability comparison.
    always_comb begin
        stable_next = SW'(1);
        if (pat == prev_pat) stable_next = (stable_cnt == '1) ? stable_cnt : stable_cnt + SW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_pat    <= '0;
            stable_cnt  <= '0;
            converged_r <= 1'b0;
        end else if (state == EVAL) begin
            prev_pat    <= pat;
            stable_cnt  <= stable_next;
            converged_r <= (stable_next >= SW'(STABLE_WINDOWS));
        end else if (state == COUNT && !enable) begin
            stable_cnt  <= '0;
            converged_r <= 1'b0;
        end
    end

    assign converged = converged_r;
`else
    assign converged = 1'b0;
`endif

endmodule

// File: tb/tb_spike_pattern_decoder.sv
// Directed bench for spike_pattern_decoder: WINDOW=16 main instance plus a CNT_W=3 instance
// sharing the same stimulus to exercise counter saturation.
module tb_spike_pattern_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       out_ready;
    logic [6:0] spikes;

    logic [6:0] pattern_out, sat_pattern;
    logic       out_valid, sat_valid;
    logic       overrun, sat_overrun;
    logic       converged, sat_converged;
    logic [1:0] state_dbg, sat_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spike_pattern_decoder #(.N(7), .WINDOW(16), .CNT_W(8), .THRESH(4), .STABLE_WINDOWS(3)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .spikes(spikes), .out_ready(out_ready),
        .pattern_out(pattern_out), .out_valid(out_valid), .overrun(overrun),
        .converged(converged), .state_dbg(state_dbg)
    );

    spike_pattern_decoder #(.N(7), .WINDOW(16), .CNT_W(3), .THRESH(4), .STABLE_WINDOWS(3)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .spikes(spikes), .out_ready(out_ready),
        .pattern_out(sat_pattern), .out_valid(sat_valid), .overrun(sat_overrun),
        .converged(sat_converged), .state_dbg(sat_state)
    );

    typedef struct {
        logic [6:0] ma;
        int         na;
        logic [6:0] mb;
        int         nb;
        logic [6:0] exp_pat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        spikes    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Drives 16 count cycles: first na cycles mask ma, next nb cycles mask mb, rest idle.
    task automatic drive_window(input logic [6:0] ma, input int na, input logic [6:0] mb, input int nb);
        for (int c = 0; c < 16; c++) begin
            if (c < na) spikes = ma;
            else if (c < na + nb) spikes = mb;
            else spikes = '0;
            tick();
        end
        spikes = '0;
    endtask

    initial begin
        vecs[0] = '{7'b0000011, 3, 7'b0000001, 2, 7'b0000001};
        vecs[1] = '{7'h7F,      4, 7'h00,      0, 7'h7F};
        vecs[2] = '{7'h7F,      3, 7'h00,      0, 7'h00};
        vecs[3] = '{7'b1010101, 4, 7'b0101010, 3, 7'b1010101};
        vecs[4] = '{7'b1111000, 2, 7'b1100000, 2, 7'b1100000};
        vecs[5] = '{7'h7F,     16, 7'h00,      0, 7'h7F};
        vecs[6] = '{7'h00,     16, 7'h00,      0, 7'h00};
        vecs[7] = '{7'b0001000, 8, 7'b0001000, 8, 7'b0001000};

        do_reset();
        chk("reset_pattern", pattern_out, 7'h00);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        chk("reset_converged", converged, 1'b0);
        chk("reset_state", state_dbg, 2'd0);

        // Table: one full window per record, result accepted immediately.
        for (int v = 0; v < 8; v++) begin
            out_ready = 1'b1;
            enable    = 1'b1;
            tick();
            chk("vec_state_count", state_dbg, 2'd1);
            drive_window(vecs[v].ma, vecs[v].na, vecs[v].mb, vecs[v].nb);
            chk("vec_valid_early", out_valid, 1'b0);
            enable = 1'b0;
            tick();
            chk("vec_valid", out_valid, 1'b1);
            chk("vec_pattern", pattern_out, vecs[v].exp_pat);
            chk("vec_sat_pattern", sat_pattern, vecs[v].exp_pat);
            tick();
            chk("vec_valid_drop", out_valid, 1'b0);
            chk("vec_state_idle", state_dbg, 2'd0);
`ifndef STABILITY_CHECK_EN
            chk("vec_converged", converged, 1'b0);
`endif
        end

        // Overrun: second result dropped while first waits unaccepted.
        do_reset();
        enable = 1'b1;
        tick();
        drive_window(7'b0000001, 5, 7'h00, 0);
        tick();
        chk("ovr_first_valid", out_valid, 1'b1);
        chk("ovr_first_pattern", pattern_out, 7'b0000001);
        drive_window(7'b0000010, 5, 7'h00, 0);
        enable = 1'b0;
        tick();
        chk("ovr_held_pattern", pattern_out, 7'b0000001);
        chk("ovr_held_valid", out_valid, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("ovr_valid_drop", out_valid, 1'b0);
        chk("ovr_sticky", overrun, 1'b1);

        // Accept in the same cycle as EVAL: new result loads, out_valid stays high.
        do_reset();
        enable = 1'b1;
        tick();
        drive_window(7'b0000001, 5, 7'h00, 0);
        tick();
        drive_window(7'h7F, 16, 7'h00, 0);
        enable    = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("swap_valid", out_valid, 1'b1);
        chk("swap_pattern", pattern_out, 7'h7F);
        chk("swap_no_overrun", overrun, 1'b0);
        tick();
        chk("swap_valid_drop", out_valid, 1'b0);

        // Asynchronous reset in the middle of a count with spikes active.
        do_reset();
        enable = 1'b1;
        tick();
        drive_window(7'h7F, 16, 7'h00, 0);
        tick();
        drive_window(7'h7F, 16, 7'h00, 0);
        tick();
        chk("rst_pre_overrun", overrun, 1'b1);
        spikes = 7'h7F;
        tick();
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_pattern", pattern_out, 7'h00);
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_overrun", overrun, 1'b0);
        chk("rst_async_state", state_dbg, 2'd0);
        enable  = 1'b0;
        spikes  = '0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("rst_release_state", state_dbg, 2'd0);
        chk("rst_release_valid", out_valid, 1'b0);

        // Abort after 8 counted cycles, then a fresh window must start from zero.
        do_reset();
        out_ready = 1'b1;
        enable    = 1'b1;
        tick();
        spikes = 7'b0000100;
        repeat (8) tick();
        enable = 1'b0;
        tick();
        chk("abort_state", state_dbg, 2'd0);
        spikes = '0;
        begin
            logic saw_valid;
            saw_valid = 1'b0;
            for (int c = 0; c < 20; c++) begin
                tick();
                saw_valid |= out_valid;
            end
            chk("abort_no_valid", saw_valid, 1'b0);
        end
        enable = 1'b1;
        tick();
        drive_window(7'b0000100, 2, 7'b0000010, 4);
        enable = 1'b0;
        chk("reen_valid_early", out_valid, 1'b0);
        tick();
        chk("reen_valid", out_valid, 1'b1);
        chk("reen_pattern", pattern_out, 7'b0000010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
